write_back: RTL and testbench
=============================

// Module: write_back
// PURPOSE
// - Write-back stage of the pipelined MIPS core: MEM/WB pipeline register plus result select.
// - Captures MEM-stage results on clk; drives register-file write port (data, dest, enable) one cycle later.
// - MemtoReg=0 selects ALUResult, MemtoReg=1 selects load data (aligned/extended), Link selects PC+4 (jal/jalr).
// PARAMETERS
// - DATA_W   32  datapath width (only 32 supported)
// - REG_AW   5   register-address width
// PORTS
// - clk        in   1       rising-edge clock (single clock domain)
// - rst_n      in   1       asynchronous active-low reset
// - en         in   1       1: MEM/WB register loads; 0: holds (stall)
// - flush      in   1       1 (with en): load a bubble (RegWrite=0, data regs 0)
// - RegWrite   in   1       MEM-stage register-write enable
// - MemtoReg   in   1       0: ALUResult, 1: readData
// - Link       in   1       1: write pcPlus4 (overrides MemtoReg)
// - loadSize   in   2       00 word, 01 half, 10 byte, 11 reserved (treated as word)
// - loadSigned in   1       1: sign-extend sub-word loads, 0: zero-extend
// - addrLow    in   2       ALUResult[1:0] of the load address (byte offset)
// - readData   in   32      raw word from data memory
// - ALUResult  in   32      ALU output
// - pcPlus4    in   32      PC+4 of the instruction
// - writeReg   in   5       destination register number
// - writeData  out  32      value to register file / forwarding unit
// - wbReg      out  5       registered destination register
// - wbRegWrite out  1       register-file write enable
// BEHAVIOUR
// - Reset (rst_n=0, async): all MEM/WB registers 0 -> writeData=0, wbReg=0, wbRegWrite=0.
// - Posedge clk, en=1, flush=0: capture all inputs; en=1, flush=1: capture bubble; en=0: hold.
// - flush ignored when en=0. Reset dominates en/flush.
// - Latency: inputs at edge N appear on outputs after edge N; outputs combinational from registers only.
// - writeData priority: Link -> pcPlus4_q; else MemtoReg -> aligned load; else ALUResult_q.
// - Load alignment is big-endian: byte offset 0 = readData[31:24], 3 = [7:0];
//   half offset 0 = [31:16], offset 2 = [15:0]; addrLow[0] ignored for half, addrLow ignored for word.
// - Byte/half extended to 32 bits per loadSigned_q; word passes through unchanged.
// - wbRegWrite = RegWrite_q && (wbReg != 0): writes to $0 are suppressed.
// - No internal arithmetic besides extension; no overflow cases.
// STRUCTURE
// - Package mips_pkg: loadSize encodings (LS_WORD=2'b00, LS_HALF=2'b01, LS_BYTE=2'b10), DATA_W, REG_AW.
// - Sub-module wb_load_align: combinational (readData, addrLow, loadSize, loadSigned) -> 32-bit load value.
// - Top: MEM/WB register block, wb_load_align instance, 3-way result mux, $0 write gating.
// TESTING
// - Reset: rst_n=0 with nonzero inputs -> writeData=0, wbReg=0, wbRegWrite=0 immediately (no clock).
// - ALU path: MemtoReg=0, readData=13, ALUResult=23, writeReg=8, RegWrite=1, clock -> writeData=23, wbReg=8, wbRegWrite=1.
// - Load path: MemtoReg=1, loadSize=00, readData=13, ALUResult=23, clock -> writeData=13.
// - Sub-word: readData=32'h80FF7F01, lb addrLow=0 -> 32'hFFFFFF80; lbu addrLow=1 -> 32'h000000FF;
//   lh addrLow=2 -> 32'h00007F01; lh addrLow=0 -> 32'hFFFF80FF.
// - Link/$0: Link=1, pcPlus4=32'h00400008 -> writeData=32'h00400008; writeReg=0, RegWrite=1 -> wbRegWrite=0.
// - Stall/flush: en=0 for 2 cycles with changing inputs -> outputs held; en=1, flush=1 -> wbRegWrite=0, writeData=0.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS datapath widths and load-size encodings
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    localparam logic [1:0] LS_WORD = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_BYTE = 2'b10;

endpackage

// File: rtl/wb_load_align.sv
// rtl/wb_load_align.sv - big-endian sub-word select and sign/zero extension for loads
module wb_load_align
    import mips_pkg::*;
(
    input  logic [31:0] readData,
    input  logic [1:0]  addrLow,
    input  logic [1:0]  loadSize,
    input  logic        loadSigned,
    output logic [31:0] loadValue
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    always_comb begin
        byteSel   = 8'h00;
        halfSel   = 16'h0000;
        loadValue = readData;

        // Big-endian: offset 0 is the most significant byte of the word.
        case (addrLow)
            2'd0:    byteSel = readData[31:24];
            2'd1:    byteSel = readData[23:16];
            2'd2:    byteSel = readData[15:8];
            default: byteSel = readData[7:0];
        endcase

        halfSel = addrLow[1] ? readData[15:0] : readData[31:16];

        case (loadSize)
            LS_BYTE: loadValue = {{24{loadSigned & byteSel[7]}}, byteSel};
            LS_HALF: loadValue = {{16{loadSigned & halfSel[15]}}, halfSel};
            default: loadValue = readData;
        endcase
    end

endmodule

// File: rtl/write_back.sv
// rtl/write_back.sv - MEM/WB pipeline register and register-file write-back select
module write_back
    import mips_pkg::*;
#(
    parameter int DATA_W = mips_pkg::DATA_W,
    parameter int REG_AW = mips_pkg::REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              flush,
    input  logic              RegWrite,
    input  logic              MemtoReg,
    input  logic              Link,
    input  logic [1:0]        loadSize,
    input  logic              loadSigned,
    input  logic [1:0]        addrLow,
    input  logic [DATA_W-1:0] readData,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] pcPlus4,
    input  logic [REG_AW-1:0] writeReg,
    output logic [DATA_W-1:0] writeData,
    output logic [REG_AW-1:0] wbReg,
    output logic              wbRegWrite
);

    logic              regWriteQ;
    logic              memtoRegQ;
    logic              linkQ;
    logic [1:0]        loadSizeQ;
    logic              loadSignedQ;
    logic [1:0]        addrLowQ;
    logic [DATA_W-1:0] readDataQ;
    logic [DATA_W-1:0] aluResultQ;
    logic [DATA_W-1:0] pcPlus4Q;
    logic [DATA_W-1:0] loadValue;

    // A bubble clears every field so writeData reads 0 as well as disabling the write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regWriteQ   <= 1'b0;
            memtoRegQ   <= 1'b0;
            linkQ       <= 1'b0;
            loadSizeQ   <= LS_WORD;
            loadSignedQ <= 1'b0;
            addrLowQ    <= 2'b00;
            readDataQ   <= '0;
            aluResultQ  <= '0;
            pcPlus4Q    <= '0;
            wbReg       <= '0;
        end else if (en) begin
            if (flush) begin
                regWriteQ   <= 1'b0;
                memtoRegQ   <= 1'b0;
                linkQ       <= 1'b0;
                loadSizeQ   <= LS_WORD;
                loadSignedQ <= 1'b0;
                addrLowQ    <= 2'b00;
                readDataQ   <= '0;
                aluResultQ  <= '0;
                pcPlus4Q    <= '0;
                wbReg       <= '0;
            end else begin
                regWriteQ   <= RegWrite;
                memtoRegQ   <= MemtoReg;
                linkQ       <= Link;
                loadSizeQ   <= loadSize;
                loadSignedQ <= loadSigned;
                addrLowQ    <= addrLow;
                readDataQ   <= readData;
                aluResultQ  <= ALUResult;
                pcPlus4Q    <= pcPlus4;
                wbReg       <= writeReg;
            end
        end
    end

    wb_load_align u_load_align (
        .readData   (readDataQ),
        .addrLow    (addrLowQ),
        .loadSize   (loadSizeQ),
        .loadSigned (loadSignedQ),
        .loadValue  (loadValue)
    );

    always_comb begin
        if (linkQ)
            writeData = pcPlus4Q;
        else if (memtoRegQ)
            writeData = loadValue;
        else
            writeData = aluResultQ;
    end

    // $0 is hardwired to zero, so writes to it never reach the register file.
    assign wbRegWrite = regWriteQ && (wbReg != '0);

endmodule

// File: tb/tb_write_back.sv
// tb/tb_write_back.sv - scoreboard bench for the write-back stage
module tb_write_back;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en, flush, RegWrite, MemtoReg, Link, loadSigned;
    logic [1:0]  loadSize, addrLow;
    logic [31:0] readData, ALUResult, pcPlus4;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [4:0]  wbReg;
    logic        wbRegWrite;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  r;
        logic        we;
        string       tag;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    write_back dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .flush      (flush),
        .RegWrite   (RegWrite),
        .MemtoReg   (MemtoReg),
        .Link       (Link),
        .loadSize   (loadSize),
        .loadSigned (loadSigned),
        .addrLow    (addrLow),
        .readData   (readData),
        .ALUResult  (ALUResult),
        .pcPlus4    (pcPlus4),
        .writeReg   (writeReg),
        .writeData  (writeData),
        .wbReg      (wbReg),
        .wbRegWrite (wbRegWrite)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic e, input logic f, input logic rw, input logic m2r,
                         input logic lnk, input logic [1:0] ls, input logic sgn,
                         input logic [1:0] al, input logic [31:0] rd, input logic [31:0] alu,
                         input logic [31:0] pc, input logic [4:0] wr);
        en = e; flush = f; RegWrite = rw; MemtoReg = m2r; Link = lnk;
        loadSize = ls; loadSigned = sgn; addrLow = al;
        readData = rd; ALUResult = alu; pcPlus4 = pc; writeReg = wr;
    endtask

    task automatic step(input string tag, input logic [31:0] expD, input logic [4:0] expR,
                        input logic expWe);
        exp_t x;
        @(posedge clk);
        #1;
        x.d = expD; x.r = expR; x.we = expWe; x.tag = tag;
        expQ.push_back(x);
    endtask

    task automatic drain();
        int n = 0;
        while (expQ.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("scoreboard_drain", 32'(expQ.size()), 32'd0);
    endtask

    // Monitor: compares registered outputs mid-cycle against the oldest expectation.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (expQ.size() != 0) begin
                x = expQ.pop_front();
                chk({x.tag, "_data"}, writeData, x.d);
                chk({x.tag, "_reg"}, 32'(wbReg), 32'(x.r));
                chk({x.tag, "_we"}, 32'(wbRegWrite), 32'(x.we));
            end
        end
    end

    localparam logic [31:0] RD = 32'h80FF7F01;

    initial begin
        rst_n = 1'b0;
        drive(1, 0, 1, 0, 0, 2'b00, 0, 2'd0, 32'd13, 32'd23, 32'h4, 5'd8);
        #1;
        chk("reset_data", writeData, 32'd0);
        chk("reset_reg", 32'(wbReg), 32'd0);
        chk("reset_we", 32'(wbRegWrite), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        //     en f rw m2r lnk ls    sgn al    readData   ALUResult      pcPlus4        writeReg
        drive(1, 0, 1, 0, 0, 2'b00, 0, 2'd0, 32'd13, 32'd23, 32'h0, 5'd8);
        step("alu", 32'd23, 5'd8, 1'b1);
        drive(1, 0, 1, 1, 0, 2'b00, 0, 2'd0, 32'd13, 32'd23, 32'h0, 5'd8);
        step("lw", 32'd13, 5'd8, 1'b1);
        drive(1, 0, 1, 1, 0, 2'b00, 1, 2'd3, RD, 32'd23, 32'h0, 5'd9);
        step("lw_off3", 32'h80FF7F01, 5'd9, 1'b1);
        drive(1, 0, 1, 1, 0, 2'b10, 1, 2'd0, RD, 32'd23, 32'h0, 5'd9);
        step("lb_0", 32'hFFFFFF80, 5'd9, 1'b1);
        drive(1, 0, 1, 1, 0, 2'b10, 0, 2'd1, RD, 32'd23, 32'h0, 5'd9);
        step("lbu_1", 32'h000000FF, 5'd9, 1'b1);
        drive(1, 0, 1, 1, 0, 2'b10, 1, 2'd2, RD, 32'd23, 32'h0, 5'd9);
        step("lb_2", 32'h0000007F, 5'd9, 1'b1);
        drive(1, 0, 1, 1, 0, 2'b10, 1, 2'd3, RD, 32'd23, 32'h0, 5'd9);
        step("lb_3", 32'h00000001, 5'd9, 1'b1);
        drive(1, 0, 1, 1, 0, 2'b10, 0, 2'd0, RD, 32'd23, 32'h0, 5'd9);
        step("lbu_0", 32'h00000080, 5'd9, 1'b1);
        drive(1, 0, 1, 1, 0, 2'b01, 1, 2'd2, RD, 32'd23, 32'h0, 5'd10);
        step("lh_2", 32'h00007F01, 5'd10, 1'b1);
        drive(1, 0, 1, 1, 0, 2'b01, 1, 2'd0, RD, 32'd23, 32'h0, 5'd10);
        step("lh_0", 32'hFFFF80FF, 5'd10, 1'b1);
        drive(1, 0, 1, 1, 0, 2'b01, 0, 2'd1, RD, 32'd23, 32'h0, 5'd10);
        step("lhu_1", 32'h000080FF, 5'd10, 1'b1);
        drive(1, 0, 1, 1, 0, 2'b01, 1, 2'd3, RD, 32'd23, 32'h0, 5'd10);
        step("lh_3", 32'h00007F01, 5'd10, 1'b1);
        drive(1, 0, 1, 1, 0, 2'b11, 1, 2'd1, RD, 32'd23, 32'h0, 5'd10);
        step("ls_rsvd", 32'h80FF7F01, 5'd10, 1'b1);
        drive(1, 0, 1, 1, 1, 2'b10, 1, 2'd0, RD, 32'd23, 32'h00400008, 5'd31);
        step("link", 32'h00400008, 5'd31, 1'b1);
        drive(1, 0, 1, 0, 0, 2'b00, 0, 2'd0, RD, 32'd55, 32'h0, 5'd0);
        step("reg0", 32'd55, 5'd0, 1'b0);
        drive(1, 0, 0, 0, 0, 2'b00, 0, 2'd0, RD, 32'd66, 32'h0, 5'd5);
        step("nowrite", 32'd66, 5'd5, 1'b0);

        drive(1, 0, 1, 0, 0, 2'b00, 0, 2'd0, 32'd0, 32'h1234, 32'h0, 5'd12);
        step("pre_stall", 32'h1234, 5'd12, 1'b1);
        drive(0, 0, 1, 1, 1, 2'b10, 1, 2'd1, RD, 32'hAAAA, 32'h8, 5'd3);
        step("stall1", 32'h1234, 5'd12, 1'b1);
        drive(0, 1, 0, 0, 0, 2'b01, 0, 2'd2, RD, 32'hBBBB, 32'hC, 5'd4);
        step("stall_flush", 32'h1234, 5'd12, 1'b1);
        drive(1, 1, 1, 0, 1, 2'b00, 0, 2'd0, RD, 32'hCCCC, 32'h10, 5'd7);
        step("flush", 32'd0, 5'd0, 1'b0);
        drive(1, 0, 1, 0, 0, 2'b00, 0, 2'd0, RD, 32'hDDDD, 32'h0, 5'd6);
        step("post_flush", 32'hDDDD, 5'd6, 1'b1);
        drain();

        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_data", writeData, 32'd0);
        chk("async_rst_reg", 32'(wbReg), 32'd0);
        chk("async_rst_we", 32'(wbRegWrite), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 0, 1, 0, 0, 2'b00, 0, 2'd0, RD, 32'h77, 32'h0, 5'd2);
        step("after_rst", 32'h77, 5'd2, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
